multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
// Multi-cycle MIPS control FSM: sequences the shared datapath (one memory, one ALU) over FETCH/DECODE/EXEC/MEM/WB.
// Consumes IR opcode and a memory ready handshake. Drives mux selects, write enables and ALU_op.
// Keeps a retired-instruction counter and flags illegal opcodes.
// PARAMETERS
// CNT_W    32   width of retired-instruction counter
// PORTS
// clk          in   1      sole clock, rising edge
// rst          in   1      reset, asynchronous, active-high
// op           in   6      IR[31:26]; valid from DECODE onward
// mem_ready    in   1      memory access completes this cycle
// PCWrite      out  1      unconditional PC load
// PCWriteCond  out  1      PC load if ALU zero
// IorD         out  1      0=PC addresses memory, 1=ALUOut
// MemRead      out  1      memory read request
// MemWrite     out  1      memory write request
// IRWrite      out  1      latch instruction register
// RegDst       out  1      1=rd, 0=rt
// MemtoReg     out  1      1=MDR, 0=ALUOut
// RegWrite     out  1      register file write
// ALUSrcA      out  1      0=PC, 1=reg A
// ALUSrcB      out  2      00=B, 01=4, 10=ext imm, 11=sext imm<<2
// ExtZero      out  1      1=zero-extend imm (ori)
// PCSource     out  2      00=ALU result, 01=ALUOut, 10=jump target
// ALU_op       out  3      000 add, 100 sub, 010 or, 110 lui, 001 funct-decode
// R_type       out  1      R-type in EXEC
// illegal      out  1      1-cycle pulse on unknown opcode
// state        out  4      current state (debug)
// retired      out  CNT_W  instructions completed
// BEHAVIOUR
// - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, ori 001101, lui 001111, j 000010.
// - States: 0 FETCH, 1 DECODE, 2 MEM_ADR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR, 6 R_EXEC, 7 R_WB, 8 BR, 9 I_EXEC, 10 I_WB, 11 JMP.
// - Reset (async): state=FETCH, retired=0. All outputs 0 while rst=1. MemRead first asserts in the first cycle after rst falls.
// - Unlisted outputs are 0 in every state.
// - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000.
//   - Holds while mem_ready=0.
//   - IRWrite=1 and PCWrite=1 (PCSource=00) only in the mem_ready=1 cycle, then -> DECODE.
// - DECODE (1 cycle): ALUSrcA=0, ALUSrcB=11, ALU_op=000 (branch target).
//   - lw/sw -> MEM_ADR; R -> R_EXEC; beq -> BR; ori/lui -> I_EXEC; j -> JMP.
//   - Other opcode: illegal=1 for this cycle -> FETCH; not counted.
// - MEM_ADR: ALUSrcA=1, ALUSrcB=10, ALU_op=000; lw -> MEM_RD, sw -> MEM_WR.
// - MEM_RD: MemRead=1, IorD=1; hold until mem_ready=1 -> MEM_WB.
// - MEM_WR: MemWrite=1, IorD=1; hold until mem_ready. MemWrite stays high while waiting. mem_ready=1 -> FETCH (retire).
// - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH (retire).
// - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=001, R_type=1 -> R_WB.
// - R_WB: RegWrite=1, RegDst=1, MemtoReg=0; keeps ALU_op=001 -> FETCH (retire).
// - BR: ALUSrcA=1, ALUSrcB=00, ALU_op=100, PCWriteCond=1, PCSource=01 -> FETCH (retire).
// - I_EXEC: ALUSrcA=1, ALUSrcB=10, ExtZero=(ori); ALU_op=010 ori / 110 lui -> I_WB.
// - I_WB: RegWrite=1, RegDst=0, MemtoReg=0; holds I_EXEC ALU/ext selects -> FETCH (retire).
// - JMP: PCWrite=1, PCSource=10 -> FETCH (retire).
// - retired increments by 1 on each retire edge; wraps modulo 2^CNT_W.
// - op is sampled only in DECODE/MEM_ADR/I_EXEC/I_WB; changes elsewhere are ignored.
// - mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
// - Latency with mem_ready tied 1: lw 5 cycles; sw, R, ori, lui 4; beq, j 3.
// - Illegal state encodings (12-15) -> FETCH next cycle, all outputs 0.
// - rst mid-instruction: immediate return to FETCH, counter cleared, no partial write enable held.
// TESTING
// - mem_ready=1, op=100011: states 0,1,2,3,4,0; RegWrite+MemtoReg only in state 4; retired 0->1.
// - FETCH with mem_ready low 3 cycles: MemRead=1 for 4 cycles; IRWrite/PCWrite high only in the 4th.
// - op=000100: BR asserts PCWriteCond=1, PCSource=01, ALU_op=100; 3 cycles total.
// - op=001101 then 001111: I_EXEC ALU_op=010 with ExtZero=1, then 110 with ExtZero=0; RegDst=0 in I_WB.
// - op=111111: illegal pulses 1 cycle in DECODE, next state FETCH, retired unchanged.
// - Assert rst during MEM_WR wait: MemWrite drops asynchronously, state=0, retired=0; fetch resumes on release.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle control FSM and the shared MIPS datapath.
// The controller drives the control word; the datapath supplies opcode and memory handshake.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       op;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             ExtZero;
  logic [1:0]       PCSource;
  logic [2:0]       ALU_op;
  logic             R_type;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ExtZero,
           PCSource, ALU_op, R_type, illegal, state, retired
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ExtZero,
           PCSource, ALU_op, R_type, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// memory and ALU, counts retired instructions and flags unknown opcodes.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEM_ADR = 4'd2;
  localparam logic [3:0] S_MEM_RD  = 4'd3;
  localparam logic [3:0] S_MEM_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_R_EXEC  = 4'd6;
  localparam logic [3:0] S_R_WB    = 4'd7;
  localparam logic [3:0] S_BR      = 4'd8;
  localparam logic [3:0] S_I_EXEC  = 4'd9;
  localparam logic [3:0] S_I_WB    = 4'd10;
  localparam logic [3:0] S_JMP     = 4'd11;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] retired_reg;
  logic             retire;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero, r_type, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic       is_ori;

  assign is_ori = (bus.op == OP_ORI);

  always_comb begin
    state_next    = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 3'b000;
    r_type        = 1'b0;
    illegal       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        state_next = S_FETCH;
        // PC+4 and IR are only committed on the cycle the memory delivers.
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:   state_next = S_MEM_ADR;
          OP_R:           state_next = S_R_EXEC;
          OP_BEQ:         state_next = S_BR;
          OP_ORI, OP_LUI: state_next = S_I_EXEC;
          OP_J:           state_next = S_JMP;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read   = 1'b1;
        i_or_d     = 1'b1;
        state_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_MEM_WR;
        end
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        r_type     = 1'b1;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = 3'b001;
        retire    = 1'b1;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b100;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_I_EXEC, S_I_WB: begin
        // I_WB keeps the I_EXEC operand path so the ALU result stays stable for the write.
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        ext_zero   = is_ori;
        alu_op     = is_ori ? 3'b010 : 3'b110;
        reg_write  = (state_reg == S_I_WB);
        retire     = (state_reg == S_I_WB);
        state_next = (state_reg == S_I_EXEC) ? S_I_WB : S_FETCH;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        retired_reg <= retired_reg + CNT_W'(1);
      end
    end
  end

  // Reset gates the control word combinationally so no enable survives a mid-instruction reset.
  assign bus.PCWrite     = pc_write      & ~rst;
  assign bus.PCWriteCond = pc_write_cond & ~rst;
  assign bus.IorD        = i_or_d        & ~rst;
  assign bus.MemRead     = mem_read      & ~rst;
  assign bus.MemWrite    = mem_write     & ~rst;
  assign bus.IRWrite     = ir_write      & ~rst;
  assign bus.RegDst      = reg_dst       & ~rst;
  assign bus.MemtoReg    = mem_to_reg    & ~rst;
  assign bus.RegWrite    = reg_write     & ~rst;
  assign bus.ALUSrcA     = alu_src_a     & ~rst;
  assign bus.ALUSrcB     = alu_src_b     & {2{~rst}};
  assign bus.ExtZero     = ext_zero      & ~rst;
  assign bus.PCSource    = pc_source     & {2{~rst}};
  assign bus.ALU_op      = alu_op        & {3{~rst}};
  assign bus.R_type      = r_type        & ~rst;
  assign bus.illegal     = illegal       & ~rst;
  assign bus.state       = state_reg;
  assign bus.retired     = retired_reg;

endmodule
